shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//   Parametrised shift register with a start/busy/done handshake. Shifts N positions left or right
//   on command, one position per clock. Replaces the fixed 8-bit fill-with-1 DFF chain; that
//   behaviour is reproduced with serial_in=1, dir=left, count=WIDTH.
//   Has parallel load and serial output. Serves as the shared shifting datapath for LAB-level
//   designs (LED chasers, serializers, thermometer codes).
// PARAMETERS
//   WIDTH      8     register width in bits (>=2)
//   CNT_W      4     width of count port; shifts per command 0..2**CNT_W-1
//   RESET_VAL  0     value q takes on reset (WIDTH bits)
// PORTS
//   clk        in   1       clock; all state updates on rising edge
//   reset      in   1       synchronous, active-high reset
//   load       in   1       parallel load request (IDLE only)
//   din        in   WIDTH   parallel load data
//   start      in   1       shift command request (IDLE only)
//   dir        in   1       0 = left (toward MSB, fill q[0]); 1 = right (toward LSB, fill q[WIDTH-1])
//   count      in   CNT_W   number of single-bit shifts for this command
//   serial_in  in   1       fill bit for vacated position
//   q          out  WIDTH   register contents
//   serial_out out  1       registered copy of the bit shifted out by the most recent shift
//   busy       out  1       high while in SHIFT
//   done       out  1       one-cycle pulse when a command completes
// BEHAVIOUR
//   Reset: q=RESET_VAL, serial_out=0, busy=0, done=0, state=IDLE. Overrides everything, including mid-command.
//   FSM: IDLE -> SHIFT (start, count>0) | DONE (start, count==0); SHIFT -> DONE after last shift; DONE -> IDLE.
//   IDLE: if load, then q<=din; load wins over start in the same cycle (start dropped, no done pulse).
//     Else if start, then latch dir and count into internal dir_r and rem_r.
//   SHIFT: each edge shifts q one position using dir_r. Fill bit = serial_in as sampled at that edge.
//     serial_out<=bit leaving the register; rem_r decrements. Shift at which rem_r==1 -> DONE.
//   Latency: start sampled at edge E0 gives shifts at E1..EN. busy=1 for N cycles; done=1 in the
//     cycle after EN; IDLE from E(N+1). count==0: done=1 in the cycle after E0, q unchanged, busy stays 0.
//   start/load/dir/count changes while busy or done are ignored; no queuing.
//   DONE: q holds; start is not accepted until IDLE (minimum 1 idle cycle between commands).
//   Width rules: count is unsigned; rem_r is CNT_W bits and never underflows. count>WIDTH is legal
//     (register fully refilled by serial_in).
// CONFIGURATION
//   SHIFT_ROTATE_EN defined: adds input port 'rotate' (1 bit), latched with start into rotate_r.
//     When rotate_r=1 the fill bit is the bit shifted out (circular). serial_in is ignored.
//     serial_out behaves as in plain shifting.
//   Not defined: no rotate port; fill bit is always serial_in.
// STRUCTURE
//   shift_pkg: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2; DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
//   Sub-module shift_core: WIDTH-bit register plus serial_out register; inputs ld, din, sh, dir, fill.
//     shift_sequencer holds the FSM, rem_r and the fill-bit mux.
// TESTING (WIDTH=8, CNT_W=4, RESET_VAL=0)
//   1 Reset 2 cycles -> q=8'h00, serial_out=0, busy=0, done=0.
//   2 load din=8'hA5; start dir=0 count=3 serial_in=1 -> q 4B,97,2F; busy 3 cycles; done 1 cycle;
//     serial_out=1.
//   3 load 8'hA5; start dir=1 count=2 serial_in=0 -> q 52,29; serial_out=0; load/start while busy
//     leave q/count unaffected.
//   4 start count=0 -> done pulses the cycle after start; busy never 1; q unchanged.
//     load+start in the same cycle -> load only, no done.
//   5 reset asserted at the 2nd shift of count=5 -> next cycle q=00, IDLE, busy=0, no done pulse.
//   6 q=00, serial_in=1, dir=0, count=8 -> q=8'hFF after 8 shifts (legacy thermometer).
//     With SHIFT_ROTATE_EN: load 8'h81, rotate=1, dir=0, count=1 -> q=8'h03.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer: FSM states and shift direction.
package shift_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/shift_core.sv
// WIDTH-bit shift register with parallel load and a registered copy of the outgoing bit.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             sh,
  input  logic             dir,
  input  logic             fill,
  output logic [WIDTH-1:0] q,
  output logic             serial_out
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= RESET_VAL;
      serial_out <= 1'b0;
    end else if (ld) begin
      q <= din;
    end else if (sh) begin
      if (dir == DIR_LEFT) begin
        q          <= {q[WIDTH-2:0], fill};
        serial_out <= q[WIDTH-1];
      end else begin
        q          <= {fill, q[WIDTH-1:1]};
        serial_out <= q[0];
      end
    end
  end
endmodule

// File: rtl/shift_sequencer.sv
// Start/busy/done sequencer around shift_core: shifts count positions, one per clock.
// Build option SHIFT_ROTATE_EN adds a 'rotate' input for circular shifting.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  input  logic             serial_in,
`ifdef SHIFT_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);
  state_t           state;
  logic             dir_r;
  logic [CNT_W-1:0] rem_r;
  logic             ld, sh, fill;
  logic             accept;

  assign ld     = (state == ST_IDLE) && load;
  assign sh     = (state == ST_SHIFT);
  // load has priority over start in the same idle cycle
  assign accept = (state == ST_IDLE) && !load && start;

`ifdef SHIFT_ROTATE_EN
  logic rotate_r;
  always_ff @(posedge clk) begin
    if (reset)       rotate_r <= 1'b0;
    else if (accept) rotate_r <= rotate;
  end
  assign fill = rotate_r ? ((dir_r == DIR_LEFT) ? q[WIDTH-1] : q[0]) : serial_in;
`else
  assign fill = serial_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      dir_r <= DIR_LEFT;
      rem_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            dir_r <= dir;
            rem_r <= count;
            if (count != '0) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          rem_r <= rem_r - 1'b1;
          if (rem_r == CNT_W'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  shift_core #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_core (
    .clk        (clk),
    .reset      (reset),
    .ld         (ld),
    .din        (din),
    .sh         (sh),
    .dir        (dir_r),
    .fill       (fill),
    .q          (q),
    .serial_out (serial_out)
  );
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (WIDTH=8, CNT_W=4, RESET_VAL=0).
module tb_shift_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] din;
  logic       start;
  logic       dir;
  logic [3:0] count;
  logic       serial_in;
`ifdef SHIFT_ROTATE_EN
  logic       rotate;
`endif
  logic [7:0] q;
  logic       serial_out, busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(8), .CNT_W(4), .RESET_VAL(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .din        (din),
    .start      (start),
    .dir        (dir),
    .count      (count),
    .serial_in  (serial_in),
`ifdef SHIFT_ROTATE_EN
    .rotate     (rotate),
`endif
    .q          (q),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance one edge and settle just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; din = '0; start = 1'b0;
    dir = 1'b0; count = '0; serial_in = 1'b0;
`ifdef SHIFT_ROTATE_EN
    rotate = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    chk("rst_q", q, 8'h00);
    chk("rst_so", serial_out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);

    // left shift by 3 with fill 1
    load = 1'b1; din = 8'hA5; tick(); load = 1'b0;
    chk("t2_load", q, 8'hA5);
    start = 1'b1; dir = 1'b0; count = 4'd3; serial_in = 1'b1; tick(); start = 1'b0;
    chk("t2_e0_q", q, 8'hA5);
    chk("t2_e0_busy", busy, 1'b1);
    tick(); chk("t2_e1_q", q, 8'h4B); chk("t2_e1_busy", busy, 1'b1); chk("t2_e1_so", serial_out, 1'b1);
    tick(); chk("t2_e2_q", q, 8'h97); chk("t2_e2_busy", busy, 1'b1); chk("t2_e2_so", serial_out, 1'b0);
    tick(); chk("t2_e3_q", q, 8'h2F); chk("t2_e3_busy", busy, 1'b0);
    chk("t2_e3_done", done, 1'b1); chk("t2_e3_so", serial_out, 1'b1);
    tick(); chk("t2_idle_done", done, 1'b0); chk("t2_idle_q", q, 8'h2F);

    // right shift by 2 with fill 0; load/start while busy must be ignored
    load = 1'b1; din = 8'hA5; tick(); load = 1'b0;
    start = 1'b1; dir = 1'b1; count = 4'd2; serial_in = 1'b0; tick();
    load = 1'b1; din = 8'hFF; count = 4'd7; dir = 1'b0;
    tick(); chk("t3_e1_q", q, 8'h52); chk("t3_e1_so", serial_out, 1'b1);
    tick(); chk("t3_e2_q", q, 8'h29); chk("t3_e2_so", serial_out, 1'b0); chk("t3_e2_done", done, 1'b1);
    load = 1'b0; start = 1'b0;
    tick(); chk("t3_idle_q", q, 8'h29); chk("t3_idle_busy", busy, 1'b0); chk("t3_idle_done", done, 1'b0);

    // zero-count command and load/start collision
    start = 1'b1; count = 4'd0; tick(); start = 1'b0;
    chk("t4_c0_busy", busy, 1'b0); chk("t4_c0_done", done, 1'b1); chk("t4_c0_q", q, 8'h29);
    tick(); chk("t4_c0_done2", done, 1'b0); chk("t4_c0_busy2", busy, 1'b0);
    load = 1'b1; din = 8'h3C; start = 1'b1; count = 4'd2; tick(); load = 1'b0; start = 1'b0;
    chk("t4_ls_q", q, 8'h3C); chk("t4_ls_busy", busy, 1'b0); chk("t4_ls_done", done, 1'b0);
    tick(); chk("t4_ls_q2", q, 8'h3C); chk("t4_ls_busy2", busy, 1'b0); chk("t4_ls_done2", done, 1'b0);

    // reset in the middle of a count=5 command
    start = 1'b1; dir = 1'b0; count = 4'd5; serial_in = 1'b1; tick(); start = 1'b0;
    tick(); chk("t5_e1_q", q, 8'h79);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5_rst_q", q, 8'h00); chk("t5_rst_busy", busy, 1'b0); chk("t5_rst_done", done, 1'b0);
    tick(); chk("t5_after_q", q, 8'h00); chk("t5_after_busy", busy, 1'b0); chk("t5_after_done", done, 1'b0);

    // legacy thermometer fill: 8 left shifts of 1 into 0
    start = 1'b1; dir = 1'b0; count = 4'd8; serial_in = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i < 8) chk("t6_busy", busy, 1'b1);
    end
    chk("t6_q", q, 8'hFF); chk("t6_done", done, 1'b1); chk("t6_busy_end", busy, 1'b0);
    tick(); chk("t6_idle_done", done, 1'b0);

`ifdef SHIFT_ROTATE_EN
    load = 1'b1; din = 8'h81; tick(); load = 1'b0;
    start = 1'b1; rotate = 1'b1; dir = 1'b0; count = 4'd1; serial_in = 1'b0; tick();
    start = 1'b0; rotate = 1'b0;
    tick(); chk("rot_q", q, 8'h03); chk("rot_so", serial_out, 1'b1); chk("rot_done", done, 1'b1);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
